// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Brief    : Edge-captured, maskable, fixed-priority interrupt controller that
//            drives the trap strobes and presents a vector to fetch.
// Revision : 1.0
// ============================================================================
module int_ctrl #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               int_en,
    input  logic               insn_boundary,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_din,
    input  logic               eoi,
    input  logic               redirect_ack,
    output logic               ir_tsf,
    output logic               ks,
    output logic               vec_valid,
    output logic [31:0]        vec_addr,
    output logic [4:0]         irq_id,
    output logic               busy,
    output logic [NUM_IRQ-1:0] mask_q
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SAVE   = 2'd1;
    localparam logic [1:0] c_VECTOR = 2'd2;
    localparam logic [1:0] c_ACTIVE = 2'd3;

    logic [1:0]         r_state;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [4:0]         r_irq_id;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_clear;
    logic [4:0]         w_win_id;
    logic               w_take;
    logic [31:0]        w_vec_addr;

    assign w_rise     = irq & ~r_irq_d;
    assign w_eligible = r_pending & r_mask;
    assign w_take     = (r_state == c_IDLE) && (|w_eligible) && int_en && insn_boundary;

    // Scan from the top down so the lowest eligible index is the last write.
    always_comb begin
        w_win_id = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_id = 5'(i);
            end
        end
    end

    always_comb begin
        w_clear = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clear[i] = (r_state == c_SAVE) && (r_irq_id == 5'(i));
        end
    end

    // A fresh edge on the line being cleared wins, so it is ORed in last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_d   <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_irq_d   <= irq;
            r_pending <= (r_pending & ~w_clear) | w_rise;
            if (mask_we) begin
                r_mask <= mask_din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_irq_id <= 5'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_take) begin
                        r_state  <= c_SAVE;
                        r_irq_id <= w_win_id;
                    end
                end
                c_SAVE: begin
                    r_state <= c_VECTOR;
                end
                c_VECTOR: begin
                    if (redirect_ack) begin
                        r_state <= c_ACTIVE;
                    end
                end
                c_ACTIVE: begin
                    if (eoi) begin
                        r_state  <= c_IDLE;
                        r_irq_id <= 5'd0;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_irq_id <= 5'd0;
                end
            endcase
        end
    end

    assign w_vec_addr = VEC_BASE + ({27'd0, r_irq_id} << VEC_SHIFT);

    // Strobes are gated by rst_n so a reset can never leave a partial pulse.
    assign ir_tsf    = (r_state == c_SAVE) && rst_n;
    assign ks        = (r_state == c_SAVE) && rst_n;
    assign vec_valid = (r_state == c_VECTOR);
    assign vec_addr  = vec_valid ? w_vec_addr : 32'd0;
    assign irq_id    = r_irq_id;
    assign busy      = (r_state != c_IDLE);
    assign mask_q    = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Brief    : Directed scenarios plus randomized traffic against a reference
//            model of the interrupt controller.
// Revision : 1.0
// ============================================================================
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq = 8'h00;
    logic        int_en = 1'b0;
    logic        insn_boundary = 1'b0;
    logic        mask_we = 1'b0;
    logic [7:0]  mask_din = 8'h00;
    logic        eoi = 1'b0;
    logic        redirect_ack = 1'b0;
    logic        ir_tsf;
    logic        ks;
    logic        vec_valid;
    logic [31:0] vec_addr;
    logic [4:0]  irq_id;
    logic        busy;
    logic [7:0]  mask_q;

    int n_cmp = 0;
    int n_err = 0;

    int_ctrl #(
        .NUM_IRQ   (8),
        .VEC_BASE  (32'h0000_0100),
        .VEC_SHIFT (4)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq           (irq),
        .int_en        (int_en),
        .insn_boundary (insn_boundary),
        .mask_we       (mask_we),
        .mask_din      (mask_din),
        .eoi           (eoi),
        .redirect_ack  (redirect_ack),
        .ir_tsf        (ir_tsf),
        .ks            (ks),
        .vec_valid     (vec_valid),
        .vec_addr      (vec_addr),
        .irq_id        (irq_id),
        .busy          (busy),
        .mask_q        (mask_q)
    );

    always #5 clk = ~clk;

    // Reference model: a request is remembered on its rising edge, a service
    // walks through save / vector / active phases, and the lowest enabled
    // pending request is chosen whenever the controller is free.
    int         m_phase;
    int         m_id;
    logic [7:0] m_pend;
    logic [7:0] m_prev;
    logic [7:0] m_mask;
    logic [7:0] m_rise;

    assign m_rise = irq & ~m_prev;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_id    <= 0;
            m_pend  <= 8'h00;
            m_prev  <= 8'h00;
            m_mask  <= 8'hFF;
        end else begin
            m_prev <= irq;
            if (mask_we) m_mask <= mask_din;
            if (m_phase == 1) m_pend <= (m_pend & ~(8'h01 << m_id)) | m_rise;
            else              m_pend <= m_pend | m_rise;
            if (m_phase == 0 && (m_pend & m_mask) != 8'h00 && int_en && insn_boundary) begin
                m_id    <= lowest(m_pend & m_mask);
                m_phase <= 1;
            end else if (m_phase == 1) begin
                m_phase <= 2;
            end else if (m_phase == 2 && redirect_ack) begin
                m_phase <= 3;
            end else if (m_phase == 3 && eoi) begin
                m_phase <= 0;
                m_id    <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_tsf(output int n);
        n = 0;
        while (ir_tsf !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // From the SAVE cycle with redirect_ack high, run the service to IDLE.
    task automatic finish_service();
        tick();
        tick();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ir_tsf, ks, vec_valid, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000", {ir_tsf, ks, vec_valid, busy});
        end
        n_cmp++;
        if (vec_addr !== 32'd0 || irq_id !== 5'd0) begin
            n_err++;
            $display("FAIL reset_vec: got addr %h id %0d want 0/0", vec_addr, irq_id);
        end
        n_cmp++;
        if (mask_q !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_mask: got %h want ff", mask_q);
        end
    endtask

    task automatic test_single_irq();
        int_en = 1'b1; insn_boundary = 1'b1; redirect_ack = 1'b1;
        irq[3] = 1'b1;
        tick();
        n_cmp++;
        if (ir_tsf !== 1'b0) begin
            n_err++; $display("FAIL single_early: ir_tsf got %b want 0", ir_tsf);
        end
        tick();
        n_cmp++;
        if ({ir_tsf, ks, busy} !== 3'b111 || irq_id !== 5'd3) begin
            n_err++;
            $display("FAIL single_save: tsf/ks/busy %b id %0d want 111 id 3", {ir_tsf, ks, busy}, irq_id);
        end
        tick();
        n_cmp++;
        if (vec_valid !== 1'b1 || vec_addr !== 32'h130 || ir_tsf !== 1'b0) begin
            n_err++;
            $display("FAIL single_vec: valid %b addr %h tsf %b want 1 130 0", vec_valid, vec_addr, ir_tsf);
        end
        tick();
        n_cmp++;
        if (vec_valid !== 1'b0 || busy !== 1'b1 || irq_id !== 5'd3) begin
            n_err++;
            $display("FAIL single_active: valid %b busy %b id %0d want 0 1 3", vec_valid, busy, irq_id);
        end
        irq = 8'h00;
        repeat (4) tick();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || irq_id !== 5'd0) begin
            n_err++; $display("FAIL single_eoi: busy %b id %0d want 0 0", busy, irq_id);
        end
    endtask

    task automatic test_priority();
        int n;
        int extra;
        irq = 8'h24;
        tick();
        irq = 8'h00;
        wait_tsf(n);
        n_cmp++;
        if (n >= 20 || irq_id !== 5'd2) begin
            n_err++; $display("FAIL prio_first: waited %0d id %0d want <20 id 2", n, irq_id);
        end
        tick();
        n_cmp++;
        if (vec_addr !== 32'h120) begin
            n_err++; $display("FAIL prio_first_vec: got %h want 120", vec_addr);
        end
        tick();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        wait_tsf(n);
        n_cmp++;
        if (n >= 20 || irq_id !== 5'd5) begin
            n_err++; $display("FAIL prio_second: waited %0d id %0d want <20 id 5", n, irq_id);
        end
        tick();
        n_cmp++;
        if (vec_addr !== 32'h150) begin
            n_err++; $display("FAIL prio_second_vec: got %h want 150", vec_addr);
        end
        tick();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        extra = 0;
        repeat (20) begin
            tick();
            if (ir_tsf === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++; $display("FAIL prio_third: got %0d extra services want 0", extra);
        end
    endtask

    task automatic test_masking();
        int seen;
        mask_we = 1'b1; mask_din = 8'hFB;
        tick();
        mask_we = 1'b0;
        n_cmp++;
        if (mask_q !== 8'hFB) begin
            n_err++; $display("FAIL mask_write: got %h want fb", mask_q);
        end
        irq[2] = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (ir_tsf === 1'b1) seen++;
        end
        irq = 8'h00;
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL mask_block: got %0d strobes want 0", seen);
        end
        mask_we = 1'b1; mask_din = 8'hFF;
        tick();
        mask_we = 1'b0;
        n_cmp++;
        if (ir_tsf !== 1'b0) begin
            n_err++; $display("FAIL mask_early: ir_tsf got %b want 0", ir_tsf);
        end
        tick();
        n_cmp++;
        if (ir_tsf !== 1'b1 || irq_id !== 5'd2) begin
            n_err++; $display("FAIL mask_unmask: tsf %b id %0d want 1 id 2", ir_tsf, irq_id);
        end
        finish_service();
    endtask

    task automatic test_enable_gating();
        int seen;
        int_en = 1'b0;
        irq[0] = 1'b1;
        tick();
        irq = 8'h00;
        seen = 0;
        repeat (50) begin
            tick();
            if (ir_tsf === 1'b1 || ks === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL gate_int_en: got %0d strobes want 0", seen);
        end
        int_en = 1'b1; insn_boundary = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (ir_tsf === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL gate_boundary: got %0d strobes want 0", seen);
        end
        insn_boundary = 1'b1;
        tick();
        n_cmp++;
        if (ir_tsf !== 1'b1 || irq_id !== 5'd0) begin
            n_err++; $display("FAIL gate_open: tsf %b id %0d want 1 id 0", ir_tsf, irq_id);
        end
        finish_service();
    endtask

    task automatic test_handshake();
        int n;
        int seen;
        redirect_ack = 1'b0;
        irq[4] = 1'b1;
        tick();
        irq = 8'h00;
        wait_tsf(n);
        tick();
        irq[1] = 1'b1;
        n_cmp++;
        if (n >= 20 || vec_valid !== 1'b1 || vec_addr !== 32'h140) begin
            n_err++; $display("FAIL hs_enter: wait %0d valid %b addr %h want 1 140", n, vec_valid, vec_addr);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            irq = 8'h00;
            n_cmp++;
            if (vec_valid !== 1'b1 || vec_addr !== 32'h140) begin
                n_err++; $display("FAIL hs_hold: cycle %0d valid %b addr %h want 1 140", i, vec_valid, vec_addr);
            end
        end
        redirect_ack = 1'b1;
        tick();
        n_cmp++;
        if (vec_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL hs_ack: valid %b busy %b want 0 1", vec_valid, busy);
        end
        seen = 0;
        repeat (10) begin
            tick();
            if (ir_tsf === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL hs_nested: got %0d strobes in service want 0", seen);
        end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL hs_eoi: busy %b want 0", busy);
        end
        tick();
        n_cmp++;
        if (ir_tsf !== 1'b1 || irq_id !== 5'd1) begin
            n_err++; $display("FAIL hs_next: tsf %b id %0d want 1 id 1", ir_tsf, irq_id);
        end
        finish_service();
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        redirect_ack = 1'b0;
        irq[6] = 1'b1;
        tick();
        irq = 8'h00;
        wait_tsf(n);
        tick();
        irq[7] = 1'b1;
        mask_we = 1'b1; mask_din = 8'h0F;
        tick();
        irq = 8'h00;
        mask_we = 1'b0;
        n_cmp++;
        if (n >= 20 || vec_valid !== 1'b1 || vec_addr !== 32'h160) begin
            n_err++; $display("FAIL rmid_vector: wait %0d valid %b addr %h want 1 160", n, vec_valid, vec_addr);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ir_tsf, ks, vec_valid, busy} !== 4'b0000 || mask_q !== 8'hFF || irq_id !== 5'd0) begin
            n_err++;
            $display("FAIL rmid_reset: ctrl %b mask %h id %0d want 0000 ff 0", {ir_tsf, ks, vec_valid, busy}, mask_q, irq_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        redirect_ack = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (ir_tsf === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL rmid_spurious: got %0d strobes want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [48:0] exp_v;
        logic [48:0] got_v;
        int errs;
        errs = 0;
        for (int c = 0; c < 4000; c++) begin
            irq           = irq ^ 8'($urandom & $urandom & $urandom);
            int_en        = ($urandom_range(0, 9) < 7);
            insn_boundary = ($urandom_range(0, 9) < 7);
            redirect_ack  = $urandom_range(0, 1) == 1;
            eoi           = ($urandom_range(0, 4) == 0);
            mask_we       = ($urandom_range(0, 15) == 0);
            mask_din      = 8'($urandom);
            tick();
            exp_v = {m_phase == 1, m_phase == 1, m_phase == 2,
                     (m_phase == 2) ? 32'h100 + 32'(m_id) * 32'd16 : 32'd0,
                     5'(m_id), m_phase != 0, m_mask};
            got_v = {ir_tsf, ks, vec_valid, vec_addr, irq_id, busy, mask_q};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                errs++;
                if (errs <= 10) $display("FAIL random_c%0d: got %h want %h", c, got_v, exp_v);
            end
        end
        irq = 8'h00; eoi = 1'b0; mask_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (5) tick();
        test_single_irq();
        repeat (2) tick();
        test_priority();
        test_masking();
        repeat (2) tick();
        test_enable_gating();
        repeat (2) tick();
        test_handshake();
        repeat (2) tick();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
